// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register-file write port, with a board-clear
// sequencer that sweeps INIT_VAL into every register, one address per cycle.
module regfile_write_arbiter #(
    parameter int unsigned   NREQ     = 3,
    parameter int unsigned   AW       = 4,
    parameter int unsigned   DW       = 8,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_dst,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    input  logic             init_start,
    output logic             init_busy,
    output logic             init_done,
    output logic             rf_we,
    output logic [AW-1:0]    rf_dst,
    output logic [DW-1:0]    rf_data
);

    localparam int unsigned   LW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [LW-1:0] LAST_RST  = LW'(NREQ - 1);
    localparam logic [AW-1:0] LAST_ADDR = '1;

    typedef enum logic {ARB, INIT} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   last_q, last_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   dst_q, dst_d;
    logic [DW-1:0]   data_q, data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [NREQ-1:0] eligible;
    logic            win_found;
    logic [LW-1:0]   win_idx;
    logic [NREQ-1:0] win_gnt;
    logic [AW-1:0]   win_dst;
    logic [DW-1:0]   win_data;
    logic            arb_en;

    // Round-robin pick: first eligible above last, else lowest eligible (wrap).
    always_comb begin
        eligible  = req & ~gnt_q;
        win_found = 1'b0;
        win_idx   = '0;
        win_gnt   = '0;
        win_dst   = '0;
        win_data  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!win_found && eligible[i] && (LW'(i) > last_q)) begin
                win_found = 1'b1;
                win_idx   = LW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!win_found && eligible[i]) begin
                win_found = 1'b1;
                win_idx   = LW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_found && (LW'(i) == win_idx)) begin
                win_gnt[i] = 1'b1;
                win_dst    = req_dst[i*AW +: AW];
                win_data   = req_data[i*DW +: DW];
            end
        end
    end

    // cnt_q tracks the sweep address currently presented on rf_dst.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        we_d    = 1'b0;
        dst_d   = dst_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        arb_en  = 1'b0;
        case (state_q)
            ARB: begin
                if (init_start) begin
                    state_d = INIT;
                    cnt_d   = '0;
                    we_d    = 1'b1;
                    dst_d   = '0;
                    data_d  = INIT_VAL;
                    busy_d  = 1'b1;
                end else begin
                    arb_en = 1'b1;
                end
            end
            INIT: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ARB;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    arb_en  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + AW'(1);
                    we_d   = 1'b1;
                    dst_d  = cnt_q + AW'(1);
                    data_d = INIT_VAL;
                end
            end
            default: state_d = ARB;
        endcase
        if (arb_en && win_found) begin
            gnt_d  = win_gnt;
            we_d   = 1'b1;
            dst_d  = win_dst;
            data_d = win_data;
            last_d = win_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            gnt_q   <= '0;
            we_q    <= 1'b0;
            dst_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign gnt       = gnt_q;
    assign rf_we     = we_q;
    assign rf_dst    = dst_q;
    assign rf_data   = data_q;
    assign init_busy = busy_q;
    assign init_done = done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table for arbitration,
// hand sequences for the clear sweep and asynchronous reset.
module tb_regfile_write_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned AW   = 4;
    localparam int unsigned DW   = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*AW-1:0]  req_dst;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     gnt;
    logic                init_start;
    logic                init_busy;
    logic                init_done;
    logic                rf_we;
    logic [AW-1:0]       rf_dst;
    logic [DW-1:0]       rf_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .INIT_VAL(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_dst    (req_dst),
        .req_data   (req_data),
        .gnt        (gnt),
        .init_start (init_start),
        .init_busy  (init_busy),
        .init_done  (init_done),
        .rf_we      (rf_we),
        .rf_dst     (rf_dst),
        .rf_data    (rf_data)
    );

    typedef struct {
        logic [2:0] req;
        logic [2:0] gnt;
        logic       we;
        logic [3:0] dst;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] e_gnt, input logic e_we,
                             input logic [3:0] e_dst, input logic [7:0] e_data,
                             input logic e_busy, input logic e_done);
        check({tag, ".gnt"},  32'(gnt),       32'(e_gnt));
        check({tag, ".we"},   32'(rf_we),     32'(e_we));
        check({tag, ".dst"},  32'(rf_dst),    32'(e_dst));
        check({tag, ".data"}, 32'(rf_data),   32'(e_data));
        check({tag, ".busy"}, 32'(init_busy), 32'(e_busy));
        check({tag, ".done"}, 32'(init_done), 32'(e_done));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // requester 0: dst 5 / A3, requester 1: dst 6 / B3, requester 2: dst 7 / C3
        vecs[0]  = '{3'b001, 3'b001, 1'b1, 4'h5, 8'hA3};
        vecs[1]  = '{3'b000, 3'b000, 1'b0, 4'h5, 8'hA3};
        vecs[2]  = '{3'b111, 3'b010, 1'b1, 4'h6, 8'hB3};
        vecs[3]  = '{3'b111, 3'b100, 1'b1, 4'h7, 8'hC3};
        vecs[4]  = '{3'b111, 3'b001, 1'b1, 4'h5, 8'hA3};
        vecs[5]  = '{3'b111, 3'b010, 1'b1, 4'h6, 8'hB3};
        vecs[6]  = '{3'b111, 3'b100, 1'b1, 4'h7, 8'hC3};
        vecs[7]  = '{3'b000, 3'b000, 1'b0, 4'h7, 8'hC3};
        vecs[8]  = '{3'b100, 3'b100, 1'b1, 4'h7, 8'hC3};
        vecs[9]  = '{3'b100, 3'b000, 1'b0, 4'h7, 8'hC3};
        vecs[10] = '{3'b100, 3'b100, 1'b1, 4'h7, 8'hC3};
        vecs[11] = '{3'b100, 3'b000, 1'b0, 4'h7, 8'hC3};
        vecs[12] = '{3'b100, 3'b100, 1'b1, 4'h7, 8'hC3};
        vecs[13] = '{3'b000, 3'b000, 1'b0, 4'h7, 8'hC3};

        rst        = 1'b0;
        req        = '0;
        init_start = 1'b0;
        req_dst    = {4'h7, 4'h6, 4'h5};
        req_data   = {8'hC3, 8'hB3, 8'hA3};

        #2;
        check_all("reset", 3'b000, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;

        for (int c = 0; c < 10; c++) begin
            tick();
            check_all($sformatf("idle%0d", c), 3'b000, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        end

        for (int v = 0; v < 14; v++) begin
            req = vecs[v].req;
            tick();
            check_all($sformatf("vec%0d", v), vecs[v].gnt, vecs[v].we,
                      vecs[v].dst, vecs[v].data, 1'b0, 1'b0);
        end

        // Sweep with requester 1 pending; a second init_start mid-sweep is ignored.
        req        = 3'b010;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        check_all("sweep0", 3'b000, 1'b1, 4'h0, 8'h00, 1'b1, 1'b0);
        for (int k = 1; k < 16; k++) begin
            init_start = (k == 7);
            tick();
            check_all($sformatf("sweep%0d", k), 3'b000, 1'b1, 4'(k), 8'h00, 1'b1, 1'b0);
        end
        init_start = 1'b0;
        tick();
        check_all("sweep_done", 3'b010, 1'b1, 4'h6, 8'hB3, 1'b0, 1'b1);
        req = 3'b000;
        tick();
        check_all("after_done", 3'b000, 1'b0, 4'h6, 8'hB3, 1'b0, 1'b0);

        // Asynchronous reset at sweep address 9 aborts the sweep.
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        for (int k = 1; k <= 9; k++) tick();
        check("pre_abort.dst", 32'(rf_dst), 32'(4'h9));
        rst = 1'b0;
        #1;
        check_all("abort", 3'b000, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check_all($sformatf("post_abort%0d", c), 3'b000, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        end

        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        check_all("restart0", 3'b000, 1'b1, 4'h0, 8'h00, 1'b1, 1'b0);
        tick();
        check_all("restart1", 3'b000, 1'b1, 4'h1, 8'h00, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 16x8 register file among NREQ requesters (e.g. placement step, backtrack unit, host loader) using round-robin arbitration.
- Also contains a board-clear sequencer that, on command, sweeps INIT_VAL into every register, one per cycle.
- Sits directly in front of the register file's we/dst/data inputs. Read ports are untouched.

Parameters:
NREQ, 3, number of write requesters (2..8)
AW, 4, register address width (depth = 2**AW)
DW, 8, register data width
INIT_VAL, 0, value written to every register by the clear sweep

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
req  input  NREQ  per-requester write request, level
req_dst  input  NREQ*AW  requester i's destination at bits [i*AW +: AW]
req_data  input  NREQ*DW  requester i's write data at bits [i*DW +: DW]
gnt  output  NREQ  one-hot grant, high in the cycle the write is presented
init_start  input  1  one-cycle pulse to start the clear sweep
init_busy  output  1  high while the sweep is running
init_done  output  1  one-cycle pulse after the last sweep write
rf_we  output  1  to register file write enable
rf_dst  output  AW  to register file write address
rf_data  output  DW  to register file write data

Behaviour:
- Clock and reset: single clock. rst is asynchronous, active-low.
- Reset values (rst=0): gnt=0, rf_we=0, rf_dst=0, rf_data=0, init_busy=0, init_done=0, state=ARB, sweep counter=0. The round-robin pointer is set so requester 0 has top priority.
- All outputs are registered. Nothing is combinational from input to output.
- States: ARB, INIT.

ARB state:
- At each rising edge, eligible = req & ~gnt. A requester granted in the current cycle is not eligible at this edge, so a lone continuous requester is granted every other cycle.
- If eligible != 0:
  - Pick the first set bit searching upward from (last+1) mod NREQ, wrapping.
  - Set gnt to that one-hot bit.
  - rf_we=1; rf_dst and rf_data take that requester's req_dst and req_data.
  - Update last to the winner.
- Otherwise gnt=0 and rf_we=0. rf_dst and rf_data hold their previous values.
- Handshake: a requester holds req, req_dst and req_data stable until it sees gnt=1. It then drops req, or presents its next write, in the following cycle. The write latency from a sampled request to rf_we is 1 cycle when uncontended.

Entering the sweep:
- init_start=1 in ARB moves the block to INIT at that edge. It takes priority over any requests sampled at the same edge; no grant is issued at that edge.
- The sweep counter clears to 0 and init_busy goes to 1.

INIT state:
- Each cycle: rf_we=1, rf_dst=counter, rf_data=INIT_VAL, gnt=0. The counter then increments.
- 2**AW writes total, addresses 0 through 15 in ascending order.
- After the write to address 2**AW-1:
  - Return to ARB.
  - init_busy goes to 0 and init_done=1 for exactly one cycle.
  - Normal arbitration resumes at the same edge, so a pending req may be granted in the init_done cycle.
- init_start while in INIT is ignored; there is no restart.
- req inputs are not sampled during INIT. Requesters keep req asserted and are served after the sweep, and their round-robin priority is preserved.

Boundary and robustness rules:
- rf_we is never high for more than one source in a cycle. gnt is always one-hot or zero.
- Asynchronous reset mid-sweep aborts the sweep immediately. All outputs go to their reset values and no init_done is issued.
- req bits for indices >= NREQ do not exist. NREQ=1 degenerates to alternate-cycle grants.

Test Plan:
- Reset release, req=0 -> rf_we=0, gnt=0 for 10 cycles. Assert rst=0 mid-run -> all outputs drop to 0 asynchronously, before the next clock edge.
- req=3'b001 with dst=4'h5, data=8'hA3 held for 1 cycle -> next cycle gnt=001, rf_we=1, rf_dst=5, rf_data=A3. The following cycle rf_we=0.
- req=3'b111 held continuously, distinct dst/data per requester -> grants in order 001, 010, 100, 001, ... with one write every cycle. The rf_dst sequence matches the owners.
- Only req[2] held continuously -> gnt=100 on alternate cycles, rf_we toggles 1/0.
- init_start pulse with req=3'b010 pending -> 16 cycles of rf_we=1, rf_dst=0..15, rf_data=INIT_VAL, gnt=0 and init_busy=1. Then init_done=1 for one cycle with gnt=010 in that same cycle. A second init_start at sweep cycle 7 has no effect.
- rst pulsed low at sweep address 9 -> init_busy=0, no init_done. After release, a new init_start restarts the sweep from address 0.
